// File: rtl/mul_writeback_unit_pkg.sv
// Shared definitions for the iterative write-back multiplier:
// FSM states, op encodings, register-file widths and the zero-register index.
package mul_defs;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    localparam logic OP_MUL   = 1'b0;
    localparam logic OP_UMULH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/mul_writeback_unit_step.sv
// mul_step: one combinational radix-2^BITS_PER_CYCLE shift-add step.
// Ports: accHi/mplr/multiplicand in, nextAccHi/nextMplr out.
module mul_step
    import mul_defs::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_W-1:0] accHi,
    input  logic [DATA_W-1:0] mplr,
    input  logic [DATA_W-1:0] multiplicand,
    output logic [DATA_W-1:0] nextAccHi,
    output logic [DATA_W-1:0] nextMplr
);

    localparam int B = BITS_PER_CYCLE;
    localparam int W = DATA_W + B;

    logic [W-1:0] partial;
    logic [W-1:0] sum;

    // Sum is B bits wider than accHi so the carry of the add survives.
    assign partial = {{B{1'b0}}, multiplicand}
                   * {{DATA_W{1'b0}}, mplr[B-1:0]};
    assign sum     = {{B{1'b0}}, accHi} + partial;

    // Shift {sum, mplr} right by B: low sum bits fill mplr's top.
    assign nextAccHi = sum[W-1:B];
    assign nextMplr  = {sum[B-1:0], mplr[DATA_W-1:B]};

endmodule

// File: rtl/mul_writeback_unit.sv
// Iterative 64x64 unsigned multiplier (MUL / UMULH) feeding the register
// file write port. Inputs: Clk, Reset (sync, active-high), Start, Op, BusA,
// BusB, Rd. Outputs: Busy, Done, BusW, RW, RegWr. Optional macro
// MUL_ZERO_SKIP_EN: zero operands jump straight to write-back.
module mul_writeback_unit
    import mul_defs::*;
#(
    parameter int               BITS_PER_CYCLE = 1,
    parameter logic [REG_W-1:0] XZR_IDX        = XZR
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Op,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    input  logic [REG_W-1:0]  Rd,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] BusW,
    output logic [REG_W-1:0]  RW,
    output logic              RegWr
);

    localparam int         N     = DATA_W / BITS_PER_CYCLE;
    localparam logic [6:0] N_CNT = 7'(N);

    state_t            state;
    logic [DATA_W-1:0] multiplicand;
    logic [DATA_W-1:0] mplr;
    logic [DATA_W-1:0] accHi;
    logic [DATA_W-1:0] nextAccHi;
    logic [DATA_W-1:0] nextMplr;
    logic              opReg;
    logic [REG_W-1:0]  rdReg;
    logic [6:0]        count;

    mul_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) uStep (
        .accHi       (accHi),
        .mplr        (mplr),
        .multiplicand(multiplicand),
        .nextAccHi   (nextAccHi),
        .nextMplr    (nextMplr)
    );

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            multiplicand <= '0;
            mplr         <= '0;
            accHi        <= '0;
            opReg        <= OP_MUL;
            rdReg        <= '0;
            count        <= '0;
            BusW         <= '0;
            RW           <= '0;
            Done         <= 1'b0;
            RegWr        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        multiplicand <= BusA;
                        mplr         <= BusB;
                        accHi        <= '0;
                        opReg        <= Op;
                        rdReg        <= Rd;
                        count        <= N_CNT;
`ifdef MUL_ZERO_SKIP_EN
                        if (BusA == '0 || BusB == '0) begin
                            state <= WB;
                            BusW  <= '0;
                            RW    <= Rd;
                            Done  <= 1'b1;
                            RegWr <= (Rd != XZR_IDX);
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    // N shift-add edges, then one edge with count at 0
                    // that registers the write-back beat from the product.
                    if (count != 7'd0) begin
                        accHi <= nextAccHi;
                        mplr  <= nextMplr;
                        count <= count - 7'd1;
                    end else begin
                        state <= WB;
                        BusW  <= (opReg == OP_UMULH) ? accHi : mplr;
                        RW    <= rdReg;
                        Done  <= 1'b1;
                        RegWr <= (rdReg != XZR_IDX);
                    end
                end
                WB: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    RegWr <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_writeback_unit.sv
// Directed self-checking bench for mul_writeback_unit.
// Honours MUL_ZERO_SKIP_EN for the zero-operand latency expectation.
module tb_mul_writeback_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [4:0]  Rd;
    logic        Busy;
    logic        Done;
    logic [63:0] BusW;
    logic [4:0]  RW;
    logic        RegWr;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 65;

    mul_writeback_unit dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .BusA (BusA),
        .BusB (BusB),
        .Rd   (Rd),
        .Busy (Busy),
        .Done (Done),
        .BusW (BusW),
        .RW   (RW),
        .RegWr(RegWr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Issue one request and watch 140 cycles. lat = k of the first cycle
    // after edge E+k with Done high (-1 if none). hold>0 keeps Start high
    // with different operands for that many cycles after accept.
    task automatic runOp(
        input  logic        op,
        input  logic [63:0] a,
        input  logic [63:0] b,
        input  logic [4:0]  rd,
        input  int          hold,
        output int          lat,
        output int          doneCnt,
        output int          wrCnt,
        output logic [63:0] w,
        output logic [4:0]  rwo,
        output logic        wrAtDone,
        output logic        busyAfter
    );
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        BusA  = a;
        BusB  = b;
        Rd    = rd;
        @(posedge Clk);
        lat       = -1;
        doneCnt   = 0;
        wrCnt     = 0;
        w         = '0;
        rwo       = '0;
        wrAtDone  = 1'b0;
        busyAfter = 1'bx;
        for (int k = 0; k < 140; k++) begin
            @(negedge Clk);
            if (k >= hold) begin
                Start = 1'b0;
            end else begin
                BusA = 64'd9;
                BusB = 64'd9;
                Rd   = 5'd3;
            end
            if (Done === 1'b1) begin
                doneCnt++;
                if (lat < 0) begin
                    lat      = k;
                    w        = BusW;
                    rwo      = RW;
                    wrAtDone = RegWr;
                end
            end
            if (RegWr === 1'b1) wrCnt++;
            if (lat >= 0 && k == lat + 1) busyAfter = Busy;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        BusA  = '0;
        BusB  = '0;
        Rd    = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Busy, Done, RegWr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000", {Busy, Done, RegWr});
        end
        checks++;
        if (BusW !== 64'd0 || RW !== 5'd0) begin
            errors++;
            $display("FAIL reset_bus got %h/%0d want 0/0", BusW, RW);
        end
        Reset = 1'b0;
    endtask

    task automatic test_mul_basic;
        int lat, dc, wc;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
        runOp(1'b0, 64'd6, 64'd7, 5'd2, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL mul_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (w !== 64'd42) begin
            errors++;
            $display("FAIL mul_busw got %0d want 42", w);
        end
        checks++;
        if (rwo !== 5'd2 || wr !== 1'b1) begin
            errors++;
            $display("FAIL mul_write got rw=%0d wr=%b want 2/1", rwo, wr);
        end
        checks++;
        if (dc !== 1 || wc !== 1) begin
            errors++;
            $display("FAIL mul_pulses got done=%0d wr=%0d want 1/1", dc, wc);
        end
        checks++;
        if (bz !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_after got %b want 0", bz);
        end
    endtask

    task automatic test_umulh;
        int lat, dc, wc;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
        runOp(1'b1, '1, 64'd2, 5'd7, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'd1 || rwo !== 5'd7) begin
            errors++;
            $display("FAIL umulh_x2 got %h rw=%0d want 1 rw=7", w, rwo);
        end
        runOp(1'b0, '1, 64'd2, 5'd7, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL mul_wrap got %h want fffffffffffffffe", w);
        end
        runOp(1'b1, '1, '1, 5'd8, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL umulh_ones got %h want fffffffffffffffe", w);
        end
        runOp(1'b1, 64'd6, 64'd7, 5'd9, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'd0 || lat !== LAT) begin
            errors++;
            $display("FAIL umulh_small got %h lat=%0d want 0 lat=%0d", w, lat, LAT);
        end
    endtask

    task automatic test_xzr;
        int lat, dc, wc;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
        runOp(1'b0, 64'd3, 64'd5, 5'd31, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (dc !== 1 || wc !== 0) begin
            errors++;
            $display("FAIL xzr_pulses got done=%0d wr=%0d want 1/0", dc, wc);
        end
        checks++;
        if (w !== 64'd15) begin
            errors++;
            $display("FAIL xzr_busw got %0d want 15", w);
        end
    endtask

    task automatic test_start_while_busy;
        int lat, dc, wc;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
        runOp(1'b0, 64'h1000, 64'h10, 5'd10, 60, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'h10000 || rwo !== 5'd10) begin
            errors++;
            $display("FAIL busy_ignore got %h rw=%0d want 10000 rw=10", w, rwo);
        end
        checks++;
        if (dc !== 1 || wc !== 1) begin
            errors++;
            $display("FAIL busy_single got done=%0d wr=%0d want 1/1", dc, wc);
        end
    endtask

    task automatic test_reset_abort;
        int lat, dc, wc;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
        int seen;
        @(negedge Clk);
        Start = 1'b1;
        Op    = 1'b0;
        BusA  = 64'd100;
        BusB  = 64'd3;
        Rd    = 5'd12;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({Busy, Done, RegWr} !== 3'b000 || BusW !== 64'd0) begin
            errors++;
            $display("FAIL abort_clear got %b busw=%h want 000 busw=0", {Busy, Done, RegWr}, BusW);
        end
        Reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge Clk);
            if (Done === 1'b1 || RegWr === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_nowrite got %0d pulses want 0", seen);
        end
        runOp(1'b0, 64'd12, 64'd12, 5'd5, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'd144 || lat !== LAT || wr !== 1'b1) begin
            errors++;
            $display("FAIL abort_next got %0d lat=%0d wr=%b want 144 lat=%0d wr=1", w, lat, wr, LAT);
        end
    endtask

    task automatic test_zero_operand;
        int lat, dc, wc, expLat;
        logic [63:0] w;
        logic [4:0] rwo;
        logic wr, bz;
`ifdef MUL_ZERO_SKIP_EN
        expLat = 0;
`else
        expLat = LAT;
`endif
        runOp(1'b0, 64'd0, 64'd5, 5'd4, 0, lat, dc, wc, w, rwo, wr, bz);
        checks++;
        if (w !== 64'd0 || rwo !== 5'd4 || wr !== 1'b1) begin
            errors++;
            $display("FAIL zero_write got %h rw=%0d wr=%b want 0 rw=4 wr=1", w, rwo, wr);
        end
        checks++;
        if (lat !== expLat) begin
            errors++;
            $display("FAIL zero_latency got %0d want %0d", lat, expLat);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_umulh();
        test_xzr();
        test_start_while_busy();
        test_reset_abort();
        test_zero_operand();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
